// File: rtl/data_memory_io.sv
// Load/store data memory for the RV32I core: byte-enabled word RAM plus an IO window
// (output register, synchronised input, sticky rising-edge flags), all read in one cycle.
module data_memory_io #(
  parameter int ADDR_WIDTH   = 10,
  parameter int IO_IN_WIDTH  = 11,
  parameter int IO_OUT_WIDTH = 11
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [3:0]              byteena,
  input  logic [31:0]             data,
  input  logic                    wren,
  output logic [31:0]             q,
  input  logic [IO_IN_WIDTH-1:0]  io_input_bus,
  output logic [IO_OUT_WIDTH-1:0] io_output_bus
);

  localparam int DEPTH = 1 << (ADDR_WIDTH - 1);

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  logic [31:0]             mem [DEPTH];
  logic                    io_sel;
  logic [ADDR_WIDTH-2:0]   ram_idx;
  logic [1:0]              io_off;
  logic [31:0]             wmask;
  logic                    ram_we;
  logic                    out_we;
  logic                    edge_we;
  logic [IO_IN_WIDTH-1:0]  edge_clr;
  logic [31:0]             rd_data;

  logic [IO_OUT_WIDTH-1:0] out_reg;
  logic [IO_IN_WIDTH-1:0]  sync_s1;
  logic [IO_IN_WIDTH-1:0]  sync_s2;
  logic [IO_IN_WIDTH-1:0]  sync_s3;
  logic [IO_IN_WIDTH-1:0]  edge_flags;

  assign io_sel  = address[ADDR_WIDTH-1];
  assign ram_idx = address[ADDR_WIDTH-2:0];
  assign io_off  = address[1:0];
  assign wmask   = lane_mask(byteena);

  // Reset suppresses every write on its edge, the RAM included.
  assign ram_we  = wren & ~io_sel & ~reset;
  assign out_we  = wren & io_sel & (io_off == 2'd0);
  assign edge_we = wren & io_sel & (io_off == 2'd2);

  assign edge_clr = edge_we ? (data[IO_IN_WIDTH-1:0] & wmask[IO_IN_WIDTH-1:0]) : '0;

  always_ff @(posedge clock) begin
    if (ram_we) begin
      for (int n = 0; n < 4; n++) begin
        if (byteena[n]) mem[ram_idx][8*n +: 8] <= data[8*n +: 8];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (!io_sel) begin
      rd_data = mem[ram_idx];
    end else begin
      case (io_off)
        2'd0:    rd_data[IO_OUT_WIDTH-1:0] = out_reg;
        2'd1:    rd_data[IO_IN_WIDTH-1:0]  = sync_s2;
        2'd2:    rd_data[IO_IN_WIDTH-1:0]  = edge_flags;
        default: rd_data = '0;
      endcase
    end
  end

  // Registered read (read-first) and IO state; edge set takes priority over clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      q          <= '0;
      out_reg    <= '0;
      sync_s1    <= '0;
      sync_s2    <= '0;
      sync_s3    <= '0;
      edge_flags <= '0;
    end else begin
      q       <= rd_data;
      sync_s1 <= io_input_bus;
      sync_s2 <= sync_s1;
      sync_s3 <= sync_s2;
      if (out_we)
        out_reg <= (out_reg & ~wmask[IO_OUT_WIDTH-1:0]) | (data[IO_OUT_WIDTH-1:0] & wmask[IO_OUT_WIDTH-1:0]);
      edge_flags <= (edge_flags & ~edge_clr) | (sync_s2 & ~sync_s3);
    end
  end

  assign io_output_bus = out_reg;

endmodule

// File: tb/tb_data_memory_io.sv
// Directed bench for data_memory_io: RAM byte lanes, read-first, IO window, edge capture, reset.
module tb_data_memory_io;

  logic        clock;
  logic        reset;
  logic [9:0]  address;
  logic [3:0]  byteena;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic [10:0] io_input_bus;
  logic [10:0] io_output_bus;

  int errors = 0;
  int checks = 0;

  data_memory_io #(.ADDR_WIDTH(10), .IO_IN_WIDTH(11), .IO_OUT_WIDTH(11)) dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .byteena(byteena),
    .data(data),
    .wren(wren),
    .q(q),
    .io_input_bus(io_input_bus),
    .io_output_bus(io_output_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one access, clock it, and return 1ns after the edge.
  task automatic access(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d, input logic we);
    address = a;
    byteena = be;
    data    = d;
    wren    = we;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    io_input_bus = '0;
    access(10'h000, 4'h0, 32'h0, 1'b0);
    check("reset_q", q, 32'h0);
    check("reset_out", {21'h0, io_output_bus}, 32'h0);
    reset = 1'b0;

    // RAM byte lanes
    access(10'h005, 4'hF, 32'h11223344, 1'b1);
    access(10'h005, 4'h5, 32'hAABBCCDD, 1'b1);
    access(10'h005, 4'h0, 32'h0, 1'b0);
    check("ram_bytes", q, 32'h11BB33DD);

    // Read-first and region decode
    access(10'h007, 4'hF, 32'hCAFE0000, 1'b1);
    access(10'h007, 4'hF, 32'h00000005, 1'b1);
    check("read_first_old", q, 32'hCAFE0000);
    access(10'h007, 4'h0, 32'h0, 1'b0);
    check("read_after_write", q, 32'h5);
    access(10'h207, 4'hF, 32'hDEADBEEF, 1'b1);
    check("io_off3_reads0", q, 32'h0);
    access(10'h007, 4'h0, 32'h0, 1'b0);
    check("ram7_unchanged", q, 32'h5);

    // OUT register
    access(10'h200, 4'h1, 32'hFFFFFFFF, 1'b1);
    check("out_read_first", q, 32'h0);
    check("out_bus_lane0", {21'h0, io_output_bus}, 32'h0FF);
    access(10'h200, 4'h0, 32'h0, 1'b0);
    check("out_q_lane0", q, 32'h000000FF);
    access(10'h200, 4'hF, 32'hFFFFFFFF, 1'b1);
    check("out_bus_full", {21'h0, io_output_bus}, 32'h7FF);
    access(10'h200, 4'h0, 32'h0, 1'b0);
    check("out_q_full", q, 32'h000007FF);
    access(10'h3FC, 4'h0, 32'h0, 1'b0);
    check("out_alias", q, 32'h000007FF);

    // IN synchroniser latency and EDGE capture
    io_input_bus = 11'h001;
    access(10'h201, 4'h0, 32'h0, 1'b0);
    check("in_lat_k", q, 32'h0);
    access(10'h201, 4'h0, 32'h0, 1'b0);
    check("in_lat_k1", q, 32'h0);
    access(10'h201, 4'h0, 32'h0, 1'b0);
    check("in_lat_k2", q, 32'h1);
    access(10'h202, 4'h0, 32'h0, 1'b0);
    check("edge_set", q, 32'h1);
    access(10'h202, 4'hF, 32'h00000001, 1'b1);
    check("edge_clr_readfirst", q, 32'h1);
    access(10'h202, 4'h0, 32'h0, 1'b0);
    check("edge_cleared", q, 32'h0);

    // Set coinciding with clear on bit 3
    io_input_bus = 11'h009;
    access(10'h000, 4'h0, 32'h0, 1'b0);
    access(10'h000, 4'h0, 32'h0, 1'b0);
    access(10'h202, 4'hF, 32'h00000008, 1'b1);
    check("edge_coincide_old", q, 32'h0);
    access(10'h202, 4'h0, 32'h0, 1'b0);
    check("edge_set_wins", q, 32'h8);
    access(10'h202, 4'hE, 32'h00000008, 1'b1);
    access(10'h202, 4'h0, 32'h0, 1'b0);
    check("edge_lane_masked", q, 32'h8);

    // Reset mid-operation with a coinciding RAM write
    access(10'h003, 4'hF, 32'hA5A5A5A5, 1'b1);
    reset = 1'b1;
    access(10'h003, 4'hF, 32'h12345678, 1'b1);
    check("midreset_q", q, 32'h0);
    check("midreset_out", {21'h0, io_output_bus}, 32'h0);
    reset = 1'b0;
    access(10'h202, 4'h0, 32'h0, 1'b0);
    check("midreset_edge", q, 32'h0);
    access(10'h003, 4'h0, 32'h0, 1'b0);
    check("midreset_ram_kept", q, 32'hA5A5A5A5);

    // Unmapped and no-op accesses
    access(10'h201, 4'hF, 32'hFFFFFFFF, 1'b1);
    check("in_write_ignored", q, 32'h9);
    access(10'h201, 4'h0, 32'h0, 1'b0);
    check("in_after_write", q, 32'h9);
    access(10'h203, 4'h0, 32'h0, 1'b0);
    check("off3_zero", q, 32'h0);
    access(10'h005, 4'h0, 32'hFFFFFFFF, 1'b1);
    check("noop_ram_old", q, 32'h11BB33DD);
    access(10'h005, 4'h0, 32'h0, 1'b0);
    check("noop_ram_kept", q, 32'h11BB33DD);
    access(10'h200, 4'hF, 32'h00000123, 1'b1);
    check("out_set_123", {21'h0, io_output_bus}, 32'h123);
    access(10'h200, 4'h0, 32'hFFFFFFFF, 1'b1);
    check("noop_out_kept", {21'h0, io_output_bus}, 32'h123);
    access(10'h202, 4'h0, 32'hFFFFFFFF, 1'b1);
    check("noop_edge_old", q, 32'h9);
    access(10'h202, 4'h0, 32'h0, 1'b0);
    check("noop_edge_kept", q, 32'h9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_io.md
# data_memory_io

Parametrised data-memory block for the RV32I core's load/store port: a byte-enabled word RAM plus a memory-mapped IO window behind the same port. The IO window has a writable output register, a synchronised input register and a sticky rising-edge capture register. All reads have a fixed one-cycle latency, matching the memory's registered-input behaviour. The core sees one uniform load path with no special case for IO accesses.

## Interface
- ADDR_WIDTH, 10, word-address width; address[ADDR_WIDTH-1] selects the IO window; RAM depth is 2^(ADDR_WIDTH-1) words.
- IO_IN_WIDTH, 11, width of io_input_bus (1..32).
- IO_OUT_WIDTH, 11, width of io_output_bus (1..32).
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- address  in  ADDR_WIDTH  word address.
- byteena  in  4  byte-lane enables for writes; bit n covers data[8n+7:8n].
- data  in  32  write data.
- wren  in  1  write enable.
- q  out  32  registered read data.
- io_input_bus  in  IO_IN_WIDTH  asynchronous external inputs.
- io_output_bus  out  IO_OUT_WIDTH  output register contents.

## Operation
- Region decode: address[ADDR_WIDTH-1]=0 selects RAM at index address[ADDR_WIDTH-2:0]; =1 selects IO with offset address[1:0]; other IO address bits are ignored (aliasing).
- IO map:
  - offset 0 OUT: read/write; holds IO_OUT_WIDTH bits.
  - offset 1 IN: read-only; holds the synchronised input.
  - offset 2 EDGE: sticky rise flags; write 1 to clear.
  - offset 3: reads 0; writes ignored.
- Reads always return zero-extended data; bits above the register width read 0.
- RAM write: on an edge with wren=1 and RAM selected, each byte lane with byteena[n]=1 is written. RAM is not reset; its contents are undefined after configuration.
- OUT write: same byte-lane rule. Bits at or above IO_OUT_WIDTH are discarded. io_output_bus drives the OUT register directly.
- IN path: two-flop synchroniser (s1, s2), then a third flop s3 holds the previous s2 value. IN reads s2.
- EDGE: bit i sets on any edge where s2[i]=1 and s3[i]=0. A write at offset 2 clears bit i where data[i]=1 and bit i lies in an enabled byte lane. When set and clear coincide on the same bit, set wins.
- Writes to offset 1 or offset 3 have no effect.
- q source: at each edge q loads the value of the addressed location before that edge's write (read-first). No enable is needed; q updates every cycle.
- wren=1 with byteena=0 is a no-op write; q still updates.
- Reset (edge with reset=1): q=0, io_output_bus=0, s1/s2/s3=0, EDGE=0. All writes, RAM included, are suppressed on that edge. A write coinciding with reset is lost.

## Timing
- Read latency: address presented at edge k gives q valid after edge k+1, i.e. in the cycle following presentation. Throughput is one access per cycle. Back-to-back mixed reads and writes are legal.
- Write latency: state updates at the presenting edge. A read of the same address in the next cycle returns the new data. A read in the same cycle returns the old data.
- Input latency:
  - An io_input_bus change stable before edge k appears in s2 after edge k+1.
  - It is readable in q after edge k+2 when IN is addressed from edge k+1.
  - The EDGE bit sets at edge k+2.
- OUT write at edge k: io_output_bus changes right after edge k.
- Reset values: q=0, io_output_bus=0. After reset deasserts, the first read result is available one cycle after the first address edge.

## Test plan
- RAM byte writes: write 0x11223344 (byteena=1111) to address 5, then 0xAABBCCDD with byteena=0101 to address 5, then read address 5 -> q=0x11BB33DD one cycle after the read address is presented.
- Read-first and region decode:
  - Write 0x5 to address 7 and read address 7 in the same cycle -> q shows the old value.
  - The next cycle's read -> q=0x5.
  - Write to address 0x207 (IO, offset 3) -> RAM address 7 is unchanged.
- OUT register (IO_OUT_WIDTH=11): write 0xFFFFFFFF to address 0x200, byteena=0001 -> io_output_bus=0x0FF; read address 0x200 -> q=0x000000FF.
  - Then write with byteena=1111 -> io_output_bus=0x7FF; read -> q=0x000007FF.
- IN and EDGE:
  - Drive io_input_bus=0x001 -> reading 0x201 returns 1 no earlier than 2 edges later; reading 0x202 returns 0x001.
  - Write 0x001 to 0x202 -> EDGE reads 0.
  - Raise bit 3 in the same cycle as a clear-write of 0x008 -> EDGE bit 3 remains 1.
- Reset mid-operation:
  - With OUT=0x7FF and EDGE nonzero, assert reset for one edge while wren=1 to RAM address 3 with 0x12345678 -> q=0, io_output_bus=0, EDGE=0.
  - RAM address 3 keeps its prior value.
- Unmapped and no-op accesses:
  - Write 0xFFFFFFFF to 0x201 and read 0x201 -> returns the synchronised input, not the written data.
  - Read 0x203 -> q=0.
  - wren=1 with byteena=0000 -> no state change.
